uart_tx_scheduler: RTL and testbench

Shares one UART sender among N_REQ byte sources, e.g. the rx echo controller, a status reporter and a debug console. It arbitrates round-robin, captures the winning byte, drives the sender's tx_en/tx_data handshake and tracks each frame through completion. A watchdog recovers from a sender that never starts or never finishes a frame. Runs on sysclk; the sender's baud-domain handshake is handled by pulse stretching.

---
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART sender
// Arbitrates byte sources, holds tx_en long enough for the baud domain, and tracks each frame to completion.
module uart_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter int EN_CYCLES = 1400,
  parameter int TO_CYCLES = 200000,
  parameter int TO_W      = 18
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_status,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               err_timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int EN_W  = $clog2(EN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [EN_W-1:0]    en_cnt_q;
  logic [TO_W-1:0]    wd_q;
  logic [N_REQ-1:0]   grant_q;
  logic               tx_en_q;
  logic [7:0]         tx_data_q;
  logic [15:0]        frame_cnt_q;
  logic               err_q;

  logic [2*N_REQ-1:0] req_rot;
  logic [IDX_W:0]     cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_d;
  logic [7:0]         win_byte;

  // Rotating the request vector by the pointer turns the wrapping scan into a plain lowest-bit search.
  always_comb begin
    req_rot   = {req, req} >> ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        cand      = {1'b0, ptr_q} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(N_REQ)) begin
          cand = cand - (IDX_W+1)'(N_REQ);
        end
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  assign ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      en_cnt_q    <= '0;
      wd_q        <= '0;
      grant_q     <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (tx_status && win_found) begin
            grant_q   <= N_REQ'(1) << win_idx;
            tx_data_q <= win_byte;
            tx_en_q   <= 1'b1;
            ptr_q     <= ptr_d;
            en_cnt_q  <= '0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (en_cnt_q == EN_W'(EN_CYCLES - 1)) begin
            tx_en_q <= 1'b0;
            wd_q    <= '0;
            state_q <= S_WAIT_BUSY;
          end else begin
            en_cnt_q <= en_cnt_q + 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (!tx_status) begin
            wd_q    <= '0;
            state_q <= S_WAIT_DONE;
          end else if (wd_q == TO_W'(TO_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_status) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q     <= S_IDLE;
          end else if (wd_q == TO_W'(TO_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
// Stimulus and sender model drive on negedge; a monitor pops expected grants and checks tx_en width.
module tb_uart_tx_scheduler;
  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_status = 1'b1;
  logic [3:0]  grant;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  logic [11:0] exp_q[$];

  uart_tx_scheduler #(.N_REQ(4), .EN_CYCLES(8), .TO_CYCLES(50), .TO_W(6)) dut (
    .sysclk(sysclk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .tx_en(tx_en), .tx_data(tx_data), .tx_status(tx_status), .busy(busy),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sysclk);
      if (grant != 0) begin
        g = grant;
        break;
      end
    end
    check("grant_seen", 32'(g != 0), 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sysclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 1);
  endtask

  // Sender: mode 0 drops tx_status 3 cycles after tx_en rises for 20 cycles, mode 1 stuck idle, mode 2 manual.
  initial begin
    int scnt;
    logic en_prev;
    scnt = 0;
    en_prev = 1'b0;
    forever begin
      @(negedge sysclk);
      if (mode == 0) begin
        if (tx_en && !en_prev) scnt = 1;
        else if (scnt != 0) scnt++;
        tx_status = !(scnt >= 3 && scnt < 23);
        if (scnt >= 23) scnt = 0;
      end else if (mode == 1) begin
        tx_status = 1'b1;
      end
      en_prev = tx_en;
    end
  end

  initial begin
    int run;
    logic run_reset;
    run = 0;
    run_reset = 1'b0;
    forever begin
      @(negedge sysclk);
      if (grant != 0) begin
        check("grant_onehot", $countones(grant), 1);
        if (exp_q.size() == 0) begin
          check("grant_expected", 32'({grant, tx_data}), 32'hFFFF_FFFF);
        end else begin
          check("grant_order", 32'({grant, tx_data}), 32'(exp_q.pop_front()));
        end
      end
      if (reset) run_reset = 1'b1;
      if (tx_en) begin
        run++;
      end else begin
        if (run > 0 && !run_reset) check("tx_en_width", run, 8);
        run = 0;
        run_reset = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual no finish required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] g;
    int n;
    repeat (3) @(negedge sysclk);
    check("rst_grant", 32'(grant), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_err", 32'(err_timeout), 0);
    reset = 1'b0;

    // 1: single request, grant on the edge after req is seen
    set_byte(0, 8'h5A);
    exp_q.push_back({4'b0001, 8'h5A});
    req = 4'b0001;
    @(negedge sysclk);
    check("t1_grant_latency", 32'(grant), 32'b0001);
    check("t1_tx_en", 32'(tx_en), 1);
    req = '0;
    wait_idle();
    check("t1_frame_cnt", 32'(frame_cnt), 1);
    check("t1_tx_data_hold", 32'(tx_data), 32'h5A);

    // 2: all four request together
    do_reset();
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
    exp_q.push_back({4'b0001, 8'h11});
    exp_q.push_back({4'b0010, 8'h22});
    exp_q.push_back({4'b0100, 8'h33});
    exp_q.push_back({4'b1000, 8'h44});
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      req = req & ~g;
    end
    wait_idle();
    check("t2_frame_cnt", 32'(frame_cnt), 4);

    // 3: req0 held, req2 raised once
    do_reset();
    set_byte(0, 8'hA0); set_byte(2, 8'hA2);
    exp_q.push_back({4'b0001, 8'hA0});
    exp_q.push_back({4'b0100, 8'hA2});
    exp_q.push_back({4'b0001, 8'hA0});
    exp_q.push_back({4'b0001, 8'hA0});
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      if (g[2]) req[2] = 1'b0;
    end
    req = '0;
    wait_idle();
    check("t3_frame_cnt", 32'(frame_cnt), 4);

    // 4: sender never starts
    do_reset();
    mode = 1;
    set_byte(0, 8'h77);
    exp_q.push_back({4'b0001, 8'h77});
    req = 4'b0001;
    wait_grant(g);
    req = '0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge sysclk);
      n++;
      if (err_timeout) break;
    end
    check("t4_timeout_latency", n, 58);
    check("t4_err", 32'(err_timeout), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_frame_cnt", 32'(frame_cnt), 0);
    mode = 0;
    set_byte(1, 8'h99);
    exp_q.push_back({4'b0010, 8'h99});
    req = 4'b0010;
    wait_grant(g);
    req = '0;
    wait_idle();
    check("t4_recover_frame_cnt", 32'(frame_cnt), 1);
    check("t4_err_sticky", 32'(err_timeout), 1);

    // 5: reset during the fourth tx_en cycle
    do_reset();
    set_byte(2, 8'hC3);
    exp_q.push_back({4'b0100, 8'hC3});
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    repeat (3) @(negedge sysclk);
    check("t5_tx_en_before", 32'(tx_en), 1);
    reset = 1'b1;
    @(negedge sysclk);
    check("t5_tx_en", 32'(tx_en), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_frame_cnt", 32'(frame_cnt), 0);
    check("t5_tx_data", 32'(tx_data), 0);
    check("t5_err", 32'(err_timeout), 0);
    @(negedge sysclk);
    reset = 1'b0;
    set_byte(1, 8'hD1); set_byte(3, 8'hD3);
    exp_q.push_back({4'b0010, 8'hD1});
    req = 4'b1010;
    wait_grant(g);
    req = '0;
    wait_idle();
    check("t5_frame_cnt_after", 32'(frame_cnt), 1);

    // 6: sender busy while idle blocks arbitration
    mode = 2;
    tx_status = 1'b0;
    set_byte(1, 8'hB6);
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      check("t6_no_grant", 32'(grant), 0);
    end
    check("t6_busy", 32'(busy), 0);
    exp_q.push_back({4'b0010, 8'hB6});
    mode = 0;
    tx_status = 1'b1;
    @(negedge sysclk);
    check("t6_grant_after_release", 32'(grant), 32'b0010);
    req = '0;
    wait_idle();
    check("t6_frame_cnt", 32'(frame_cnt), 2);

    repeat (5) @(negedge sysclk);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
